ssd_scan_mux: RTL and testbench

//  Time-multiplexed driver for the six-digit clock display. Consumes the six 7-segment codes

---
 rtl/ssd_scan_mux.sv | 118 +++++++++++
 tb/tb_ssd_scan_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// Six-digit 7-segment scan driver: one shared segment bus, one digit at a
// time, with a blank dead time per slot and 1 Hz field blinking.
// Ports: clk, reset (sync, active high), tc_time_base (1 Hz pulse),
//   blink_mask[2:0] (hours/minutes/seconds), six 7-bit digit codes,
//   seg_out[6:0], digit_en[5:0], frame_start (registered outputs).
module ssd_scan_mux #(
   parameter int         SCAN_DIV         = 50000,
   parameter int         GAP              = 16,
   parameter bit         DIGIT_ACTIVE_LOW = 1'b1,
   parameter logic [6:0] BLANK_CODE       = 7'h7F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tc_time_base,
   input  logic [2:0] blink_mask,
   input  logic [6:0] right_seconds_in,
   input  logic [6:0] left_seconds_in,
   input  logic [6:0] right_minutes_in,
   input  logic [6:0] left_minutes_in,
   input  logic [6:0] right_hours_in,
   input  logic [6:0] left_hours_in,
   output logic [6:0] seg_out,
   output logic [5:0] digit_en,
   output logic       frame_start
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [5:0] EN_OFF = DIGIT_ACTIVE_LOW ? 6'h3F : 6'h00;

   logic [DW-1:0] div;
   logic [2:0]    slot;
   logic          blink_phase;
   logic          in_gap;
   logic          field_blink;
   logic [6:0]    slot_code;
   logic [5:0]    slot_en;

   // Dead time at the head of each slot stops the previous digit's
   // segments ghosting onto the next digit.
   generate
      if (GAP == 0) begin : g_nogap
         assign in_gap = 1'b0;
      end else begin : g_gap
         localparam logic [DW:0] GAP_W = (DW+1)'(GAP);
         assign in_gap = {1'b0, div} < GAP_W;
      end
   endgenerate

   always_comb begin
      slot_code   = BLANK_CODE;
      slot_en     = 6'b000000;
      field_blink = 1'b0;
      unique case (slot)
         3'd0: begin
            slot_code   = right_seconds_in;
            slot_en     = 6'b000001;
            field_blink = blink_mask[0];
         end
         3'd1: begin
            slot_code   = left_seconds_in;
            slot_en     = 6'b000010;
            field_blink = blink_mask[0];
         end
         3'd2: begin
            slot_code   = right_minutes_in;
            slot_en     = 6'b000100;
            field_blink = blink_mask[1];
         end
         3'd3: begin
            slot_code   = left_minutes_in;
            slot_en     = 6'b001000;
            field_blink = blink_mask[1];
         end
         3'd4: begin
            slot_code   = right_hours_in;
            slot_en     = 6'b010000;
            field_blink = blink_mask[2];
         end
         3'd5: begin
            slot_code   = left_hours_in;
            slot_en     = 6'b100000;
            field_blink = blink_mask[2];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div         <= '0;
         slot        <= 3'd0;
         blink_phase <= 1'b0;
         seg_out     <= BLANK_CODE;
         digit_en    <= EN_OFF;
         frame_start <= 1'b0;
      end else begin
         frame_start <= (div == '0) && (slot == 3'd0);
         if (in_gap) begin
            seg_out  <= BLANK_CODE;
            digit_en <= EN_OFF;
         end else begin
            // Blinked digits keep their enable; only the segments go dark.
            seg_out  <= (blink_phase && field_blink) ? BLANK_CODE : slot_code;
            digit_en <= DIGIT_ACTIVE_LOW ? ~slot_en : slot_en;
         end
         if (tc_time_base)
            blink_phase <= ~blink_phase;
         if (div == DIV_LAST) begin
            div  <= '0;
            slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: scoreboarded reference model run against a GAP=2
// build and a GAP=0 build, plus directed checks of key scan events.
module tb_ssd_scan_mux;

   localparam int SD = 8;
   localparam int G  = 2;

   typedef struct {
      logic [6:0] seg;
      logic [5:0] en;
      logic       fs;
      logic [6:0] seg0;
      logic [5:0] en0;
      logic       fs0;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tc = 1'b0;
   logic [2:0] mask = 3'b000;
   logic [6:0] in_code [6];
   logic [6:0] seg_out, seg_out0;
   logic [5:0] digit_en, digit_en0;
   logic       frame_start, frame_start0;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   m_div = 0;
   int   m_slot = 0;
   bit   m_ph = 1'b0;
   int   fs_count = 0;
   logic [5:0] prev_en = 6'h3F;

   always #5 clk = ~clk;

   ssd_scan_mux #(.SCAN_DIV(SD), .GAP(G), .DIGIT_ACTIVE_LOW(1'b1),
                  .BLANK_CODE(7'h7F)) dut (
      .clk(clk), .reset(reset), .tc_time_base(tc), .blink_mask(mask),
      .right_seconds_in(in_code[0]), .left_seconds_in(in_code[1]),
      .right_minutes_in(in_code[2]), .left_minutes_in(in_code[3]),
      .right_hours_in(in_code[4]), .left_hours_in(in_code[5]),
      .seg_out(seg_out), .digit_en(digit_en), .frame_start(frame_start)
   );

   ssd_scan_mux #(.SCAN_DIV(SD), .GAP(0), .DIGIT_ACTIVE_LOW(1'b1),
                  .BLANK_CODE(7'h7F)) dut0 (
      .clk(clk), .reset(reset), .tc_time_base(tc), .blink_mask(mask),
      .right_seconds_in(in_code[0]), .left_seconds_in(in_code[1]),
      .right_minutes_in(in_code[2]), .left_minutes_in(in_code[3]),
      .right_hours_in(in_code[4]), .left_hours_in(in_code[5]),
      .seg_out(seg_out0), .digit_en(digit_en0), .frame_start(frame_start0)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void calc(input int gap, output logic [6:0] s,
                                output logic [5:0] e, output logic f);
      if (reset) begin
         s = 7'h7F; e = 6'h3F; f = 1'b0;
      end else begin
         f = (m_div == 0) && (m_slot == 0);
         if (m_div < gap) begin
            s = 7'h7F; e = 6'h3F;
         end else begin
            e = ~(6'b000001 << m_slot);
            s = (m_ph && mask[m_slot/2]) ? 7'h7F : in_code[m_slot];
         end
      end
   endfunction

   task automatic tick();
      exp_t x;
      calc(G, x.seg, x.en, x.fs);
      calc(0, x.seg0, x.en0, x.fs0);
      q.push_back(x);
      @(posedge clk);
      if (reset) begin
         m_div = 0; m_slot = 0; m_ph = 1'b0;
      end else begin
         if (tc) m_ph = ~m_ph;
         m_div++;
         if (m_div == SD) begin
            m_div = 0;
            m_slot = (m_slot + 1) % 6;
         end
      end
      #1;
      x = q.pop_front();
      chk("seg", seg_out, x.seg);
      chk("en", digit_en, x.en);
      chk("fs", frame_start, x.fs);
      chk("seg_g0", seg_out0, x.seg0);
      chk("en_g0", digit_en0, x.en0);
      chk("fs_g0", frame_start0, x.fs0);
      chk("onehot", 32'($countones(~digit_en) <= 1), 1);
      if (prev_en != 6'h3F && digit_en != 6'h3F)
         chk("consec", digit_en, prev_en);
      prev_en = digit_en;
      if (frame_start) fs_count++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse();
      tc = 1'b1;
      tick();
      tc = 1'b0;
   endtask

   task automatic wait_pos(input int slot, input int div);
      int k;
      k = 0;
      while (!(m_slot == slot && m_div == div) && k < 100) begin
         tick();
         k++;
      end
      chk("wait_pos", 32'(k < 100), 1);
   endtask

   initial begin
      in_code[0] = 7'h40; in_code[1] = 7'h79; in_code[2] = 7'h24;
      in_code[3] = 7'h30; in_code[4] = 7'h19; in_code[5] = 7'h12;

      // Reset state
      reset = 1'b1;
      run(2);
      chk("rst_en", digit_en, 6'h3F);
      chk("rst_seg", seg_out, 7'h7F);
      chk("rst_fs", frame_start, 1'b0);

      // Release: frame start with gap, then slot 0
      reset = 1'b0;
      fs_count = 0;
      tick();
      chk("c1_fs", frame_start, 1'b1);
      chk("c1_en", digit_en, 6'h3F);
      chk("c1_en_g0", digit_en0, 6'b111110);
      tick();
      chk("c2_en", digit_en, 6'h3F);
      tick();
      chk("c3_en", digit_en, 6'b111110);
      chk("c3_seg", seg_out, 7'h40);
      run(6);
      chk("c9_en", digit_en, 6'h3F);

      // Free run to end of third frame
      run(144 - 9);
      chk("fs_count", fs_count, 3);

      // Hours blink on phase 1, shown again on phase 0, mask 0 never blanks
      mask = 3'b100;
      pulse();
      run(48);
      pulse();
      run(48);
      mask = 3'b000;
      pulse();
      run(48);

      // Mid-slot input change shows one cycle later
      wait_pos(0, 4);
      in_code[0] = 7'h79;
      tick();
      chk("chg_seg", seg_out, 7'h79);
      run(4);

      // Reset during slot 3 with blink_phase set
      mask = 3'b010;
      wait_pos(3, 5);
      reset = 1'b1;
      tick();
      chk("mid_rst_en", digit_en, 6'h3F);
      chk("mid_rst_seg", seg_out, 7'h7F);
      chk("mid_rst_fs", frame_start, 1'b0);
      tc = 1'b1;
      tick();
      tc = 1'b0;
      reset = 1'b0;
      tick();
      chk("restart_fs", frame_start, 1'b1);
      run(2);
      chk("restart_en", digit_en, 6'b111110);
      run(48);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
